// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator (pixel-tick divider, H/V counters, sync/DE decode).
// Define VGA_FETCH_EN to add the lead fetch counter pair (fetch_x/fetch_y/fetch_valid).
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 4,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int FETCH_LEAD = 2,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clear,
  output logic          pclk_en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [HW-1:0] x_pixel,
  output logic [VW-1:0] y_pixel,
  output logic          sof,
  output logic          eol
`ifdef VGA_FETCH_EN
  ,
  output logic [HW-1:0] fetch_x,
  output logic [VW-1:0] fetch_y,
  output logic          fetch_valid
`endif
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] X_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] Y_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] X_EOL    = HW'(H_ACTIVE);
  localparam logic          HS_ON    = 1'(H_POL);
  localparam logic          VS_ON    = 1'(V_POL);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if ((FETCH_LEAD < 1) || (FETCH_LEAD >= H_TOTAL)) begin : g_bad_lead
    $error("vga_timing_gen: FETCH_LEAD out of range");
  end

  logic [DW-1:0] div_r;
  logic [HW-1:0] x_r, x_nxt_s;
  logic [VW-1:0] y_r, y_nxt_s;
  logic          hs_r, vs_r, de_r, sof_r, eol_r;
  logic          tick_s, load_s, frame_wrap_s;

  // Raster step: x wraps at end of line and carries into y, which wraps at end of frame.
  function automatic logic [HW+VW-1:0] advance(input logic [HW-1:0] x, input logic [VW-1:0] y);
    logic [HW-1:0] xn;
    logic [VW-1:0] yn;
    if (x == X_LAST) begin
      xn = '0;
      yn = (y == Y_LAST) ? '0 : y + 1'b1;
    end else begin
      xn = x + 1'b1;
      yn = y;
    end
    return {xn, yn};
  endfunction

  function automatic logic in_active(input logic [HW-1:0] x, input logic [VW-1:0] y);
    return (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
  endfunction

  function automatic logic hsync_level(input logic [HW-1:0] x);
    return ((int'(x) >= H_ACTIVE + H_FP) && (int'(x) < H_ACTIVE + H_FP + H_SYNC)) ? HS_ON : ~HS_ON;
  endfunction

  function automatic logic vsync_level(input logic [VW-1:0] y);
    return ((int'(y) >= V_ACTIVE + V_FP) && (int'(y) < V_ACTIVE + V_FP + V_SYNC)) ? VS_ON : ~VS_ON;
  endfunction

  assign tick_s       = en && (div_r == DIV_LAST);
  assign load_s       = clear || tick_s;
  assign frame_wrap_s = tick_s && (x_r == X_LAST) && (y_r == Y_LAST);

  // Next display position: clear restarts at the origin, a tick steps the raster, otherwise hold.
  always_comb begin
    x_nxt_s = x_r;
    y_nxt_s = y_r;
    if (clear) begin
      x_nxt_s = '0;
      y_nxt_s = '0;
    end else if (tick_s) begin
      {x_nxt_s, y_nxt_s} = advance(x_r, y_r);
    end else begin
      x_nxt_s = x_r;
      y_nxt_s = y_r;
    end
  end

  // Divider, counters and decodes; decodes load from the next position so they align with x/y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= '0;
      x_r   <= '0;
      y_r   <= '0;
      hs_r  <= ~HS_ON;
      vs_r  <= ~VS_ON;
      de_r  <= 1'b0;
      sof_r <= 1'b0;
      eol_r <= 1'b0;
    end else begin
      if (clear) begin
        div_r <= '0;
      end else if (en) begin
        div_r <= (div_r == DIV_LAST) ? '0 : div_r + 1'b1;
      end else begin
        div_r <= div_r;
      end
      if (load_s) begin
        x_r  <= x_nxt_s;
        y_r  <= y_nxt_s;
        hs_r <= hsync_level(x_nxt_s);
        vs_r <= vsync_level(y_nxt_s);
        de_r <= in_active(x_nxt_s, y_nxt_s);
      end else begin
        x_r  <= x_r;
        y_r  <= y_r;
        hs_r <= hs_r;
        vs_r <= vs_r;
        de_r <= de_r;
      end
      sof_r <= clear || frame_wrap_s;
      eol_r <= !clear && tick_s && (x_nxt_s == X_EOL);
    end
  end

  assign pclk_en = tick_s;
  assign h_sync  = hs_r;
  assign v_sync  = vs_r;
  assign de      = de_r;
  assign x_pixel = x_r;
  assign y_pixel = y_r;
  assign sof     = sof_r;
  assign eol     = eol_r;

`ifdef VGA_FETCH_EN
  localparam logic [HW-1:0] FX0 = HW'(FETCH_LEAD % H_TOTAL);
  localparam logic [VW-1:0] FY0 = VW'((FETCH_LEAD / H_TOTAL) % V_TOTAL);

  logic [HW-1:0] fx_r, fx_nxt_s;
  logic [VW-1:0] fy_r, fy_nxt_s;
  logic          fv_r;

  // Next lead position: same stepping as the display pair, restarting at the lead of the origin.
  always_comb begin
    fx_nxt_s = fx_r;
    fy_nxt_s = fy_r;
    if (clear) begin
      fx_nxt_s = FX0;
      fy_nxt_s = FY0;
    end else if (tick_s) begin
      {fx_nxt_s, fy_nxt_s} = advance(fx_r, fy_r);
    end else begin
      fx_nxt_s = fx_r;
      fy_nxt_s = fy_r;
    end
  end

  // Lead counter pair and its active-area flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fx_r <= FX0;
      fy_r <= FY0;
      fv_r <= in_active(FX0, FY0);
    end else if (load_s) begin
      fx_r <= fx_nxt_s;
      fy_r <= fy_nxt_s;
      fv_r <= in_active(fx_nxt_s, fy_nxt_s);
    end else begin
      fx_r <= fx_r;
      fy_r <= fy_r;
      fv_r <= fv_r;
    end
  end

  assign fetch_x     = fx_r;
  assign fetch_y     = fy_r;
  assign fetch_valid = fv_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 mode plus a tiny inverted-polarity, CLK_DIV=1 mode.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset, en, clear, en_s, clear_s;

  logic       pclk_en, h_sync, v_sync, de, sof, eol;
  logic [9:0] x_pixel, y_pixel;
  logic       s_pclk, s_hs, s_vs, s_de, s_sof, s_eol;
  logic [2:0] s_x, s_y;
`ifdef VGA_FETCH_EN
  logic [9:0] fetch_x, fetch_y;
  logic       fetch_valid;
  logic [2:0] s_fx, s_fy;
  logic       s_fv;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear),
    .pclk_en(pclk_en), .h_sync(h_sync), .v_sync(v_sync), .de(de),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .sof(sof), .eol(eol)
`ifdef VGA_FETCH_EN
    , .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_valid(fetch_valid)
`endif
  );

  // 8 x 6 raster: h_sync on x=5..6, v_sync on y=4, active 4x3
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .H_POL(1), .V_POL(1), .FETCH_LEAD(2)
  ) dut_s (
    .clk(clk), .reset(reset), .en(en_s), .clear(clear_s),
    .pclk_en(s_pclk), .h_sync(s_hs), .v_sync(s_vs), .de(s_de),
    .x_pixel(s_x), .y_pixel(s_y), .sof(s_sof), .eol(s_eol)
`ifdef VGA_FETCH_EN
    , .fetch_x(s_fx), .fetch_y(s_fy), .fetch_valid(s_fv)
`endif
  );

  typedef struct {
    logic en; logic clr; int ncyc;
    int x; int y; logic de; logic hs; logic vs; logic pclk; logic sof; logic eol;
    int fx; int fy; logic fv;
  } vec_t;

  vec_t tbl [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    logic bad;
    en = v.en;
    clear = v.clr;
    repeat (v.ncyc) step();
    bad = (int'(x_pixel) != v.x) || (int'(y_pixel) != v.y) || (de !== v.de) ||
          (h_sync !== v.hs) || (v_sync !== v.vs) || (pclk_en !== v.pclk) ||
          (sof !== v.sof) || (eol !== v.eol);
`ifdef VGA_FETCH_EN
    bad = bad || (int'(fetch_x) != v.fx) || (int'(fetch_y) != v.fy) || (fetch_valid !== v.fv);
`endif
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b pclk=%b sof=%b eol=%b, want x=%0d y=%0d de=%b hs=%b vs=%b pclk=%b sof=%b eol=%b",
               nm, x_pixel, y_pixel, de, h_sync, v_sync, pclk_en, sof, eol,
               v.x, v.y, v.de, v.hs, v.vs, v.pclk, v.sof, v.eol);
`ifdef VGA_FETCH_EN
      $display("FAIL %s fetch: got (%0d,%0d,%b), want (%0d,%0d,%b)",
               nm, fetch_x, fetch_y, fetch_valid, v.fx, v.fy, v.fv);
`endif
    end
  endtask

  // Small-mode check against position p = y*8 + x of the 8x6 raster.
  task automatic check_small(input string nm, input int p, input logic want_pclk, input logic want_sof);
    int x, y, q;
    logic bad;
    x = p % 8;
    y = p / 8;
    q = (p + 2) % 48;
    bad = (int'(s_x) != x) || (int'(s_y) != y) || (s_de !== ((x < 4) && (y < 3))) ||
          (s_hs !== ((x >= 5) && (x < 7))) || (s_vs !== (y == 4)) ||
          (s_pclk !== want_pclk) || (s_sof !== want_sof);
`ifdef VGA_FETCH_EN
    bad = bad || (int'(s_fx) != q % 8) || (int'(s_fy) != q / 8) ||
          (s_fv !== (((q % 8) < 4) && ((q / 8) < 3)));
`endif
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b pclk=%b sof=%b, want position %0d pclk=%b sof=%b",
               nm, s_x, s_y, s_de, s_hs, s_vs, s_pclk, s_sof, p, want_pclk, want_sof);
    end
  endtask

  initial begin
    int hs_low, eol_cnt, tick_cnt, de_cnt, vs_cnt, sof_cnt, p;

    //         en    clr   n     x    y  de    hs    vs    pclk  sof   eol   fx   fy fv
    tbl[0]  = '{1'b1, 1'b0, 3,    0,   0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2,   0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3,   0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 4,    2,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4,   0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1192, 300, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 302, 0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 10,   300, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 302, 0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 3,    300, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 302, 0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1,    301, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 303, 0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1348, 638, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 640, 0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8,    640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 642, 0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 4,    641, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 643, 0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 60,   656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 658, 0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 380,  751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 753, 0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 4,    752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 754, 0, 1'b0};

    reset = 1'b1; en = 1'b0; clear = 1'b0; en_s = 1'b0; clear_s = 1'b0;
    apply('{1'b0, 1'b0, 2, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1}, "reset_state");
    reset = 1'b0;

    for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // one full line from x=752: sync width, single eol, 800 ticks
    hs_low = 0; eol_cnt = 0; tick_cnt = 0;
    for (int i = 0; i < 3200; i++) begin
      if (pclk_en) tick_cnt++;
      step();
      if (!h_sync) hs_low++;
      if (eol) eol_cnt++;
    end
    check_int("hsync_low_clks", hs_low, 384);
    check_int("eol_per_line", eol_cnt, 1);
    check_int("ticks_per_line", tick_cnt, 800);
    apply('{1'b1, 1'b0, 0, 752, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 754, 1, 1'b0}, "line_end");

    // clear mid-frame with en low, then divider restarts from 0
    apply('{1'b1, 1'b0, 1392, 300, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 302, 2, 1'b1}, "pre_clear");
    apply('{1'b0, 1'b1, 1,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2,   0, 1'b1}, "clear_load");
    apply('{1'b1, 1'b0, 3,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2,   0, 1'b1}, "clear_div");
    apply('{1'b1, 1'b0, 1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3,   0, 1'b1}, "clear_step");
    apply('{1'b1, 1'b0, 40,   11,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13,  0, 1'b1}, "pre_areset");

    // asynchronous reset between clock edges
    #2 reset = 1'b1;
    #1;
    apply('{1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1}, "areset_now");
    step();
    reset = 1'b0;
    apply('{1'b1, 1'b0, 3, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 1'b1}, "areset_tick");
    apply('{1'b1, 1'b0, 1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 1'b1}, "areset_step");
    en = 1'b0;

    // small mode: full frame, inverted polarity, pclk_en follows en
    en_s = 1'b1;
    p = 0;
    de_cnt = 0; vs_cnt = 0; sof_cnt = 0;
    for (int k = 1; k <= 48; k++) begin
      step();
      p = k % 48;
      check_small($sformatf("frame_k%0d", k), p, 1'b1, (k == 48) ? 1'b1 : 1'b0);
      if (s_de) de_cnt++;
      if (s_vs) vs_cnt++;
      if (s_sof) sof_cnt++;
    end
    check_int("de_per_frame", de_cnt, 12);
    check_int("vsync_clks", vs_cnt, 8);
    check_int("sof_per_frame", sof_cnt, 1);

    // pause and resume: no count skipped or repeated
    step(); p = 1;
    en_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_small("pause_hold", p, 1'b0, 1'b0);
    end
    en_s = 1'b1;
    step(); p = 2;
    check_small("resume", p, 1'b1, 1'b0);

    // clear coinciding with a frame wrap, twice
    for (int r = 0; r < 2; r++) begin
      while (p != 47) begin
        step();
        p = p + 1;
      end
      check_small("pre_wrap", p, 1'b1, 1'b0);
      clear_s = 1'b1;
      step();
      clear_s = 1'b0;
      p = 0;
      check_small("clear_wrap", p, 1'b1, 1'b1);
      sof_cnt = 1;
      for (int k = 0; k < 2; k++) begin
        step();
        p = p + 1;
        if (s_sof) sof_cnt++;
      end
      check_small("after_clear_wrap", p, 1'b1, 1'b0);
      check_int("sof_count_clear_wrap", sof_cnt, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
